// File: rtl/seq_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seq_alu: multi-cycle ALU with valid/ready handshakes on both sides,   |
// | single-cycle logic/arith/shift ops plus iterative MUL/DIVU/REMU.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module seq_alu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             ZF,
  output logic             OF,
  output logic             CF,
  output logic             ERR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   f_q, f_d;
  logic               zf_q, zf_d, of_q, of_d, cf_q, cf_d, err_q, err_d;

  // Single-cycle datapath, evaluated directly on the input operands
  logic [WIDTH:0]     add_w, sub_w;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   s_f;
  logic               s_of, s_cf, s_err, is_iter;

  always_comb begin
    sh    = A[SHW-1:0];
    add_w = {1'b0, A} + {1'b0, B};
    sub_w = {1'b0, A} - {1'b0, B};
    s_f   = '0;
    s_of  = 1'b0;
    s_cf  = 1'b0;
    s_err = 1'b0;
    case (ALU_OP)
      OP_AND:  s_f = A & B;
      OP_OR:   s_f = A | B;
      OP_XOR:  s_f = A ^ B;
      OP_NOR:  s_f = ~(A | B);
      OP_ADD: begin
        s_f  = add_w[WIDTH-1:0];
        s_cf = add_w[WIDTH];
        s_of = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        s_f  = sub_w[WIDTH-1:0];
        s_cf = sub_w[WIDTH];
        s_of = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLTU: s_f = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  s_f = B << sh;
      OP_SLT:  s_f = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SRL:  s_f = B >> sh;
      OP_SRA:  s_f = $unsigned($signed(B) >>> sh);
      default: s_err = 1'b1;
    endcase
    is_iter = (ALU_OP == OP_MUL) || (ALU_OP == OP_DIVU) || (ALU_OP == OP_REMU);
  end

  // One iteration step; acc holds {hi, lo} for MUL and {rem, quo} for DIVU/REMU
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ok    = ~div_diff[WIDTH];
    if (op_q == OP_MUL) begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end else begin
      step = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
              acc_q[WIDTH-2:0], div_ok};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    acc_d   = acc_q;
    f_d     = f_q;
    zf_d    = zf_q;
    of_d    = of_q;
    cf_d    = cf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = ALU_OP;
          b_d   = B;
          cnt_d = '0;
          acc_d = {{WIDTH{1'b0}}, A};
          if (is_iter) begin
            state_d = S_BUSY;
          end else begin
            state_d = S_DONE;
            f_d     = s_f;
            zf_d    = (s_f == '0);
            of_d    = s_of;
            cf_d    = s_cf;
            err_d   = s_err;
          end
        end
      end
      S_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          f_d     = (op_q == OP_REMU) ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
          zf_d    = (f_d == '0);
          of_d    = (op_q == OP_MUL) && (step[2*WIDTH-1:WIDTH] != '0);
          cf_d    = 1'b0;
          err_d   = (op_q != OP_MUL) && (b_q == '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_AND;
      b_q     <= '0;
      acc_q   <= '0;
      f_q     <= '0;
      zf_q    <= 1'b1;
      of_q    <= 1'b0;
      cf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      f_q     <= f_d;
      zf_q    <= zf_d;
      of_q    <= of_d;
      cf_q    <= cf_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign F         = f_q;
  assign ZF        = zf_q;
  assign OF        = of_q;
  assign CF        = cf_q;
  assign ERR       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// tb_seq_alu: directed vectors; expectations queued at accept, checked by a monitor.
module tb_seq_alu;
  localparam int W = 32;
  localparam int PERIOD = 10;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, F;
  logic [3:0]   ALU_OP;
  logic         ZF, OF, CF, ERR;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_OP(ALU_OP), .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .ZF(ZF), .OF(OF), .CF(CF), .ERR(ERR)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  typedef struct {
    string       name;
    logic [W-1:0] f;
    logic        zf, of, cf, err;
    int          lat;
    time         t_acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Waits for in_ready, presents one op for exactly one accept edge.
  task automatic issue(input string nm, input logic [3:0] op, input logic [W-1:0] a, b,
                       input logic [W-1:0] f, input logic zf, of, cf, err,
                       input int lat, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    ALU_OP   = op;
    A        = a;
    B        = b;
    @(posedge clk);
    e.name = nm; e.f = f; e.zf = zf; e.of = of; e.cf = cf; e.err = err;
    e.lat = lat; e.t_acc = $time;
    if (push) q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per output transfer
  bit  seen = 1'b0;
  time t_first = 0;
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else begin
      if (out_valid && !seen) begin
        seen    = 1'b1;
        t_first = $time;
      end
      if (out_valid && out_ready) begin
        seen = 1'b0;
        if (q.size() == 0) begin
          chk("unexpected output", F, 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, " F"},   F, e.f);
          chk({e.name, " ZF"},  {31'b0, ZF},  {31'b0, e.zf});
          chk({e.name, " OF"},  {31'b0, OF},  {31'b0, e.of});
          chk({e.name, " CF"},  {31'b0, CF},  {31'b0, e.cf});
          chk({e.name, " ERR"}, {31'b0, ERR}, {31'b0, e.err});
          chk({e.name, " latency"},
              W'(int'((t_first - e.t_acc - PERIOD/2) / PERIOD) + 1), W'(e.lat));
        end
      end
    end
  end

  task automatic chk_reset_state(input string nm);
    chk({nm, " in_ready"},  {31'b0, in_ready},  32'd1);
    chk({nm, " out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({nm, " F"},   F, 32'd0);
    chk({nm, " ZF"},  {31'b0, ZF},  32'd1);
    chk({nm, " OF"},  {31'b0, OF},  32'd0);
    chk({nm, " CF"},  {31'b0, CF},  32'd0);
    chk({nm, " ERR"}, {31'b0, ERR}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; ALU_OP = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    // Reset 5 cycles into a DIVU discards it
    issue("divu_abort", 4'b1100, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("mid_reset");

    issue("add_1_2",   4'b0100, 32'd1,        32'd2,        32'd3,        0, 0, 0, 0, 1, 1);
    issue("add_of",    4'b0100, 32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 1, 0, 0, 1, 1);
    issue("add_cf",    4'b0100, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 0, 1, 0, 1, 1);
    issue("sub_3_5",   4'b0101, 32'd3,        32'd5,        32'hFFFFFFFE, 0, 0, 1, 0, 1, 1);
    issue("slt",       4'b1000, 32'hFFFFFFFF, 32'd1,        32'd1,        0, 0, 0, 0, 1, 1);
    issue("sltu",      4'b0110, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 0, 0, 0, 1, 1);
    issue("sra",       4'b1010, 32'd31,       32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 1);
    issue("srl",       4'b1001, 32'd31,       32'h80000000, 32'd1,        0, 0, 0, 0, 1, 1);
    issue("sll_33",    4'b0111, 32'd33,       32'd1,        32'd2,        0, 0, 0, 0, 1, 1);
    issue("or",        4'b0001, 32'hF0F0,     32'hFF00,     32'hFFF0,     0, 0, 0, 0, 1, 1);
    issue("xor",       4'b0010, 32'hF0F0,     32'hFF00,     32'h0FF0,     0, 0, 0, 0, 1, 1);
    issue("nor",       4'b0011, 32'hF0F0,     32'hFF00,     32'hFFFF000F, 0, 0, 0, 0, 1, 1);
    issue("mul_ovf",   4'b1011, 32'h10000,    32'h10000,    32'd0,        1, 1, 0, 0, 33, 1);
    issue("mul_7_6",   4'b1011, 32'd7,        32'd6,        32'd42,       0, 0, 0, 0, 33, 1);
    issue("divu",      4'b1100, 32'd100,      32'd7,        32'd14,       0, 0, 0, 0, 33, 1);
    issue("remu",      4'b1101, 32'd100,      32'd7,        32'd2,        0, 0, 0, 0, 33, 1);
    issue("divu_by0",  4'b1100, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 0, 0, 1, 33, 1);
    issue("remu_by0",  4'b1101, 32'd5,        32'd0,        32'd5,        0, 0, 0, 1, 33, 1);

    // Backpressure: result held, in_valid pulses ignored
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue("and_bp", 4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp F", F, 32'hF000);
      chk("bp flags", {28'b0, ZF, OF, CF, ERR}, 32'd0);
      chk("bp in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp out_valid", {31'b0, out_valid}, 32'd1);
      in_valid = i[0];
      ALU_OP   = 4'b0100;
      A        = 32'd9;
      B        = 32'd9;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp release out_valid", {31'b0, out_valid}, 32'd0);

    issue("illegal_f", 4'b1111, 32'd3, 32'd4, 32'd0, 1, 0, 0, 1, 1, 1);
    issue("illegal_e", 4'b1110, 32'd3, 32'd4, 32'd0, 1, 0, 0, 1, 1, 1);

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("queue drained", W'(q.size()), 32'd0);
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
